// File: rtl/blrowrcv.sv
// blrowrcv - receive side of the sensor row-readout interface.
//
// Captures the parallel multi-tap pixel words that the sensor drives RDLAT
// cycles after the read-enable strobe, tags each word with start-of-frame and
// end-of-row, and buffers it in a first-word-fall-through FIFO. The packer
// drains the FIFO through a valid/ready handshake.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   endet         detector enable; low holds the block idle (ovf is kept)
//   enrd          read-enable strobe from the row-readout controller
//   fstart        one-cycle frame start, reloads the row counter
//   din           sensor pixel word (TAPS*DW bits)
//   ovf_clr       clears the sticky overflow flag
//   odata/osof/oeol/odv, ordy   FIFO head word, its tags and the handshake
//   orow          row index currently being captured
//   ofdone        one-cycle pulse once the last row of a frame is written
//   ovf           sticky flag: a word was dropped because the FIFO was full
//   dbg_state_o   current capture FSM state
//
// Handshake: the head word transfers on every rising edge where odv and ordy
// are both high. odv, odata, osof and oeol only change on the edge after that
// transfer; ordy while odv is low has no effect.
module blrowrcv #(
   parameter int TAPS  = 8,
   parameter int DW    = 10,
   parameter int WPR   = 128,
   parameter int ROWS  = 1024,
   parameter int RDLAT = 2,
   parameter int AW    = 9
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 endet,
   input  logic                 enrd,
   input  logic                 fstart,
   input  logic [TAPS*DW-1:0]   din,
   input  logic                 ovf_clr,
   output logic [TAPS*DW-1:0]   odata,
   output logic                 osof,
   output logic                 oeol,
   output logic                 odv,
   input  logic                 ordy,
   output logic [9:0]           orow,
   output logic                 ofdone,
   output logic                 ovf,
   output logic [1:0]           dbg_state_o
);

   localparam int W     = TAPS * DW;
   localparam int DEPTH = 1 << AW;
   localparam int WCW   = $clog2(WPR + 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAITROW = 2'd1,
      S_CAPT    = 2'd2,
      S_ROWEND  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [RDLAT-1:0] sr_q, sr_d;
   logic [RDLAT:0]   sr_ext;
   logic             wv;
   logic             armed_q, armed_d;
   logic [WCW-1:0]   wc_q, wc_d;
   logic [WCW-1:0]   widx;
   logic             capture;
   logic             fs_pend_q, fs_pend_d;
   logic [9:0]       orow_q, orow_d;
   logic             ofdone_q, ofdone_d;
   logic             cap_vld_q, cap_vld_d;
   logic             cap_sof_q, cap_sof_d;
   logic             cap_eol_q, cap_eol_d;
   logic [W-1:0]     cap_data_q, cap_data_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic [W+1:0]     mem_q [DEPTH];
   logic [W+1:0]     head;
   logic             clr, empty, full, push, pop, drop;

   // endet low behaves like reset for everything but the overflow flag
   assign clr = rst | ~endet;

   always_comb begin
      state_d    = state_q;
      armed_d    = armed_q;
      wc_d       = wc_q;
      fs_pend_d  = fs_pend_q;
      orow_d     = orow_q;
      ofdone_d   = 1'b0;
      cap_vld_d  = 1'b0;
      cap_sof_d  = 1'b0;
      cap_eol_d  = 1'b0;
      cap_data_d = cap_data_q;
      capture    = 1'b0;
      widx       = wc_q;

      // enrd delay line; wv is enrd delayed by exactly RDLAT cycles
      sr_ext = {sr_q, enrd};
      sr_d   = sr_ext[RDLAT-1:0];
      wv     = sr_q[RDLAT-1];

      // A row may only start after wv has been seen low, so a strobe that is
      // still high when the previous row ends is not counted twice.
      if (!wv) armed_d = 1'b1;

      unique case (state_q)
         S_IDLE: begin
            if (fstart) orow_d = '0;
            if (endet) state_d = S_WAITROW;
         end
         S_WAITROW: begin
            if (fstart) orow_d = '0;
            if (wv && armed_q) begin
               capture = 1'b1;
               widx    = '0;
               armed_d = 1'b0;
               wc_d    = WCW'(1);
               state_d = (widx == WCW'(WPR - 1)) ? S_ROWEND : S_CAPT;
            end
         end
         S_CAPT: begin
            // a frame start during capture is applied at the row end
            if (fstart) fs_pend_d = 1'b1;
            if (wv) begin
               capture = 1'b1;
               wc_d    = wc_q + WCW'(1);
               if (wc_q == WCW'(WPR - 1)) state_d = S_ROWEND;
            end else begin
               // strobe ended early: truncated row
               state_d = S_ROWEND;
            end
         end
         S_ROWEND: begin
            ofdone_d  = (orow_q == 10'(ROWS - 1));
            if (fs_pend_q || fstart)            orow_d = '0;
            else if (orow_q == 10'(ROWS - 1))   orow_d = '0;
            else                                orow_d = orow_q + 10'd1;
            fs_pend_d = 1'b0;
            state_d   = S_WAITROW;
         end
         default: state_d = S_IDLE;
      endcase

      if (capture) begin
         cap_vld_d  = 1'b1;
         cap_data_d = din;
         cap_sof_d  = (orow_q == 10'd0) && (widx == '0);
         cap_eol_d  = (widx == WCW'(WPR - 1));
      end
   end

   // FIFO control. A write into a full FIFO is always dropped, even when a
   // pop happens in the same cycle.
   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == (AW+1)'(DEPTH));
   assign pop   = !empty && ordy;
   assign push  = cap_vld_q && !full;
   assign drop  = cap_vld_q && full;

   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      ovf_d    = ovf_q;
      if (drop)         ovf_d = 1'b1;
      else if (ovf_clr) ovf_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q    <= S_IDLE;
         sr_q       <= '0;
         armed_q    <= 1'b0;
         wc_q       <= '0;
         fs_pend_q  <= 1'b0;
         orow_q     <= '0;
         ofdone_q   <= 1'b0;
         cap_vld_q  <= 1'b0;
         cap_sof_q  <= 1'b0;
         cap_eol_q  <= 1'b0;
         cap_data_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         sr_q       <= sr_d;
         armed_q    <= armed_d;
         wc_q       <= wc_d;
         fs_pend_q  <= fs_pend_d;
         orow_q     <= orow_d;
         ofdone_q   <= ofdone_d;
         cap_vld_q  <= cap_vld_d;
         cap_sof_q  <= cap_sof_d;
         cap_eol_q  <= cap_eol_d;
         cap_data_q <= cap_data_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
      end
   end

   // overflow flag survives endet low; only rst clears it unconditionally
   always_ff @(posedge clk) begin
      if (rst)        ovf_q <= 1'b0;
      else if (endet) ovf_q <= ovf_d;
   end

   always_ff @(posedge clk) begin
      if (push && !clr) mem_q[wr_ptr_q] <= {cap_sof_q, cap_eol_q, cap_data_q};
   end

   // head entry falls through; outputs read zero while the FIFO is empty
   assign head        = mem_q[rd_ptr_q];
   assign odv         = !empty;
   assign odata       = odv ? head[W-1:0] : '0;
   assign oeol        = odv & head[W];
   assign osof        = odv & head[W+1];
   assign orow        = orow_q;
   assign ofdone      = ofdone_q;
   assign ovf         = ovf_q;
   assign dbg_state_o = state_q;

endmodule
